// File: rtl/opfetch_pkg.sv
// opfetch_pkg: shared definitions for the operand-fetch stage.
//   - default bus widths (register data, register address, opcode)
//   - FSM state encoding for opfetch
//   - saturating increment helper for the hazard-stall counter
package opfetch_pkg;

    localparam int DEF_DATA_W = 16;   // register data bus width
    localparam int DEF_ADDR_W = 3;    // register address width (8 registers)
    localparam int DEF_OP_W   = 5;    // opcode width
    localparam int STALL_W    = 8;    // stall counter width

    typedef enum logic [1:0] {
        OPF_IDLE  = 2'd0,
        OPF_CHECK = 2'd1,
        OPF_OUT   = 2'd2
    } opf_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/opfetch_scoreboard.sv
// opf_scoreboard: per-register busy vector for read-after-write hazard detection.
//   clk, rst_n              : clock, asynchronous active-low reset
//   set_i, set_addr_i       : mark a register busy (instruction dispatched that writes it)
//   clr_i, clr_addr_i       : mark a register free (writeback committed)
//   look1_addr_i/busy1_o    : combinational busy lookup, port 1
//   look2_addr_i/busy2_o    : combinational busy lookup, port 2
// When set and clear hit the same register in one cycle the set wins, because the
// newly dispatched writer is younger than the writeback being retired.
module opf_scoreboard #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] look1_addr_i,
    input  logic [ADDR_W-1:0] look2_addr_i,
    output logic              busy1_o,
    output logic              busy2_o
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    // One-hot decode of the set and clear addresses.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_decode
        assign set_vec[gi] = set_i && (set_addr_i == ADDR_W'(gi));
        assign clr_vec[gi] = clr_i && (clr_addr_i == ADDR_W'(gi));
    end

    // Clear first, then OR in the set so a colliding set takes priority.
    assign busy_d = (busy_q & ~clr_vec) | set_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy1_o = busy_q[look1_addr_i];
    assign busy2_o = busy_q[look2_addr_i];

endmodule

// File: rtl/opfetch.sv
// opfetch: operand-fetch stage between decoder and execute.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready, in_*    : decoded instruction from the decoder
//   rf_read*/rf_addr*/rf_data* : two combinational register-file read ports
//   wb_valid/wb_addr/wb_data   : writeback bus (forwarding + scoreboard clear)
//   out_valid/out_ready, out_* : dispatched instruction and operands to execute
//   stall_cnt                  : saturating count of hazard-stall cycles
// The stage holds one instruction at a time. In CHECK it waits until every used
// source is free (or being written back this very cycle), reads the operands,
// and parks them in OUT until execute takes them. The destination is marked
// busy only when execute actually accepts the instruction.
module opfetch
    import opfetch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int OP_W   = DEF_OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic              in_use1,
    input  logic              in_use2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_wen,
    output logic              rf_read1,
    output logic              rf_read2,
    output logic [ADDR_W-1:0] rf_addr1,
    output logic [ADDR_W-1:0] rf_addr2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_wen,
    output logic [7:0]        stall_cnt
);

    opf_state_e        state_q;

    // Latched instruction fields.
    logic [OP_W-1:0]   op_q;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic              use1_q;
    logic              use2_q;
    logic [ADDR_W-1:0] rd_q;
    logic              wen_q;

    // Registered outputs.
    logic              out_valid_q;
    logic [OP_W-1:0]   out_op_q;
    logic [DATA_W-1:0] out_a_q;
    logic [DATA_W-1:0] out_b_q;
    logic [ADDR_W-1:0] out_rd_q;
    logic              out_wen_q;
    logic [7:0]        stall_cnt_q;

    logic [DATA_W-1:0] out_a_d;
    logic [DATA_W-1:0] out_b_d;
    logic [7:0]        stall_cnt_d;

    logic busy1;
    logic busy2;
    logic fwd1;
    logic fwd2;
    logic blocked;
    logic proceed;
    logic handoff;
    logic accept;

    opf_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_i       (handoff && out_wen_q),
        .set_addr_i  (out_rd_q),
        .clr_i       (wb_valid),
        .clr_addr_i  (wb_addr),
        .look1_addr_i(rs1_q),
        .look2_addr_i(rs2_q),
        .busy1_o     (busy1),
        .busy2_o     (busy2)
    );

    // A writeback to a source in this cycle both resolves its hazard and
    // supplies the operand (the register file has not been updated yet).
    assign fwd1    = wb_valid && (wb_addr == rs1_q);
    assign fwd2    = wb_valid && (wb_addr == rs2_q);
    assign blocked = (use1_q && busy1 && !fwd1) || (use2_q && busy2 && !fwd2);

    assign proceed = (state_q == OPF_CHECK) && !blocked;
    assign handoff = (state_q == OPF_OUT) && out_ready;
    assign in_ready = (state_q == OPF_IDLE) || handoff;
    assign accept   = in_valid && in_ready;

    assign rf_addr1 = rs1_q;
    assign rf_addr2 = rs2_q;
    assign rf_read1 = proceed && use1_q;
    assign rf_read2 = proceed && use2_q;

    always_comb begin
        out_a_d = '0;
        out_b_d = '0;
        if (use1_q) out_a_d = fwd1 ? wb_data : rf_data1;
        if (use2_q) out_b_d = fwd2 ? wb_data : rf_data2;
    end

    assign stall_cnt_d = sat_inc(stall_cnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= OPF_IDLE;
            op_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            use1_q      <= 1'b0;
            use2_q      <= 1'b0;
            rd_q        <= '0;
            wen_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_rd_q    <= '0;
            out_wen_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            // accept is only possible from IDLE or on an OUT handoff.
            if (accept) begin
                op_q   <= in_op;
                rs1_q  <= in_rs1;
                rs2_q  <= in_rs2;
                use1_q <= in_use1;
                use2_q <= in_use2;
                rd_q   <= in_rd;
                wen_q  <= in_wen;
            end
            case (state_q)
                OPF_IDLE: begin
                    if (accept) state_q <= OPF_CHECK;
                end
                OPF_CHECK: begin
                    if (blocked) begin
                        stall_cnt_q <= stall_cnt_d;
                    end else begin
                        out_valid_q <= 1'b1;
                        out_op_q    <= op_q;
                        out_a_q     <= out_a_d;
                        out_b_q     <= out_b_d;
                        out_rd_q    <= rd_q;
                        out_wen_q   <= wen_q;
                        state_q     <= OPF_OUT;
                    end
                end
                OPF_OUT: begin
                    if (handoff) begin
                        out_valid_q <= 1'b0;
                        state_q     <= accept ? OPF_CHECK : OPF_IDLE;
                    end
                end
                default: state_q <= OPF_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_rd    = out_rd_q;
    assign out_wen   = out_wen_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_opfetch.sv
// Testbench for opfetch: table-driven vectors plus hand-written multi-cycle
// sequences; expected dispatches are queued at accept and checked at handoff.
module tb_opfetch;

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        use1;
        logic        use2;
        logic [2:0]  rd;
        logic        wen;
        logic [15:0] ea;
        logic [15:0] eb;
    } vec_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  rd;
        logic        wen;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  in_op;
    logic [2:0]  in_rs1, in_rs2, in_rd;
    logic        in_use1, in_use2, in_wen;
    logic        rf_read1, rf_read2;
    logic [2:0]  rf_addr1, rf_addr2;
    logic [15:0] rf_data1, rf_data2;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid, out_ready;
    logic [4:0]  out_op;
    logic [15:0] out_a, out_b;
    logic [2:0]  out_rd;
    logic        out_wen;
    logic [7:0]  stall_cnt;

    int tests = 0;
    int fails = 0;
    int rd1_cnt = 0;
    int rd2_cnt = 0;
    exp_t exp_q[$];
    logic [15:0] rf_m [8];

    always #5 clk = ~clk;

    opfetch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use1(in_use1), .in_use2(in_use2),
        .in_rd(in_rd), .in_wen(in_wen),
        .rf_read1(rf_read1), .rf_read2(rf_read2),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_wen(out_wen),
        .stall_cnt(stall_cnt)
    );

    // Register file model: R0=0x00F0, Rn=0x0011*n; writeback updates on the edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf_m[i] <= (i == 0) ? 16'h00F0 : 16'(17 * i);
        end else if (wb_valid) begin
            rf_m[wb_addr] <= wb_data;
        end
    end
    assign rf_data1 = rf_m[rf_addr1];
    assign rf_data2 = rf_m[rf_addr2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: 1 ns before each rising edge, count reads and check handoffs.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        #4;
        if (rst_n) begin
            if (rf_read1) rd1_cnt++;
            if (rf_read2) rd2_cnt++;
            if (out_valid && out_ready) begin
                a = '{op: out_op, a: out_a, b: out_b, rd: out_rd, wen: out_wen};
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL dispatch: unexpected op=%0h a=%h b=%h", out_op, out_a, out_b);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        fails++;
                        $display("FAIL dispatch: got op=%0h a=%h b=%h rd=%0d wen=%0b expected op=%0h a=%h b=%h rd=%0d wen=%0b",
                                 a.op, a.a, a.b, a.rd, a.wen, e.op, e.a, e.b, e.rd, e.wen);
                    end else begin
                        $display("[TB] dispatch op=%0h a=%h b=%h rd=%0d wen=%0b ok", a.op, a.a, a.b, a.rd, a.wen);
                    end
                end
            end
        end
    end

    function automatic vec_t mk(input logic [4:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                                input logic u1, input logic u2, input logic [2:0] rd, input logic wen,
                                input logic [15:0] ea, input logic [15:0] eb);
        vec_t v;
        v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.use1 = u1; v.use2 = u2;
        v.rd = rd; v.wen = wen; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    // Offer v starting at the current negedge; returns at the negedge after the
    // accepting edge (stage in CHECK). waited = cycles spent before acceptance.
    task automatic issue(input vec_t v, output int waited);
        bit acc = 0;
        waited = 0;
        in_op = v.op; in_rs1 = v.rs1; in_rs2 = v.rs2; in_use1 = v.use1;
        in_use2 = v.use2; in_rd = v.rd; in_wen = v.wen; in_valid = 1'b1;
        for (int k = 0; k < 300 && !acc; k++) begin
            #4;
            if (in_ready) begin
                acc = 1;
                waited = k;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (acc) exp_q.push_back('{op: v.op, a: v.ea, b: v.eb, rd: v.rd, wen: v.wen});
        else chk("accept_timeout", 32'd0, 32'd1);
    endtask

    vec_t tbl [6];
    int w;
    int snap1, snap2;

    initial begin
        tbl[0] = mk(5'd1,  3'd1, 3'd2, 1, 1, 3'd3, 0, 16'h0011, 16'h0022);
        tbl[1] = mk(5'd2,  3'd0, 3'd7, 1, 1, 3'd6, 0, 16'h00F0, 16'h0077);
        tbl[2] = mk(5'd31, 3'd5, 3'd5, 1, 0, 3'd1, 0, 16'h0055, 16'h0000);
        tbl[3] = mk(5'd0,  3'd6, 3'd3, 0, 1, 3'd2, 0, 16'h0000, 16'h0033);
        tbl[4] = mk(5'd16, 3'd7, 3'd7, 1, 1, 3'd7, 0, 16'h0077, 16'h0077);
        tbl[5] = mk(5'd9,  3'd2, 3'd4, 0, 0, 3'd5, 0, 16'h0000, 16'h0000);

        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0;
        in_use1 = 1'b0; in_use2 = 1'b0; in_rd = '0; in_wen = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_rf_read", {rf_read1, rf_read2}, 0);
        chk("rst_out_a", out_a, 0);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Table-driven, no hazards, out_ready held high: one per 2 cycles
        for (int i = 0; i < 6; i++) begin
            issue(tbl[i], w);
            if (i > 0) chk("throughput", w, 1);
        end

        // Basic: R1/R2 read, out_valid two cycles after accept
        issue(mk(5'd3, 3'd1, 3'd2, 1, 1, 3'd4, 1, 16'h0011, 16'h0022), w);
        chk("basic_rf_read", {rf_read1, rf_read2}, 2'b11);
        chk("basic_no_valid_yet", out_valid, 0);
        @(negedge clk);
        chk("basic_out_valid", out_valid, 1);
        chk("basic_rf_read_pulse", {rf_read1, rf_read2}, 2'b00);
        chk("basic_out_a", out_a, 16'h0011);

        // RAW stall on R4, released by a forwarded writeback
        issue(mk(5'd4, 3'd4, 3'd0, 1, 0, 3'd5, 0, 16'h1234, 16'h0000), w);
        chk("raw_accept_same_cycle", w, 0);
        chk("raw_blocked_no_read", rf_read1, 0);
        repeat (3) @(negedge clk);
        chk("raw_stall_cnt", stall_cnt, 3);
        chk("raw_stalled", out_valid, 0);
        wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 16'h1234;
        @(negedge clk);
        wb_valid = 1'b0;
        chk("raw_out_valid", out_valid, 1);
        chk("raw_stall_hold", stall_cnt, 3);
        @(negedge clk);

        // Backpressure
        out_ready = 1'b0;
        issue(mk(5'd7, 3'd3, 3'd6, 1, 1, 3'd1, 0, 16'h0033, 16'h0066), w);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_stable", {out_op, out_a, out_b}, {5'd7, 16'h0033, 16'h0066});
            @(negedge clk);
        end
        out_ready = 1'b1;
        issue(mk(5'd9, 3'd7, 3'd0, 1, 1, 3'd2, 1, 16'h0077, 16'h00F0), w);
        chk("bp_accept_on_release", w, 0);

        // Set/clear collision on R2: set must win
        @(negedge clk);
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'h5555;
        @(negedge clk);
        wb_valid = 1'b0;
        issue(mk(5'd1, 3'd2, 3'd0, 1, 0, 3'd3, 0, 16'h6666, 16'h0000), w);
        repeat (2) @(negedge clk);
        chk("collision_busy_stall", stall_cnt, 5);
        chk("collision_stalled", out_valid, 0);
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'h6666;
        @(negedge clk);
        wb_valid = 1'b0;
        chk("collision_release", out_valid, 1);
        @(negedge clk);

        // Unused operands on a busy register: no reads, zero operands, no stall
        issue(mk(5'd10, 3'd5, 3'd6, 1, 1, 3'd5, 1, 16'h0055, 16'h0066), w);
        @(negedge clk);
        snap1 = rd1_cnt; snap2 = rd2_cnt;
        issue(mk(5'd5, 3'd5, 3'd5, 0, 0, 3'd0, 0, 16'h0000, 16'h0000), w);
        chk("unused_no_read", {rf_read1, rf_read2}, 2'b00);
        @(negedge clk);
        chk("unused_no_stall", out_valid, 1);
        chk("unused_stall_cnt", stall_cnt, 5);
        @(negedge clk);
        chk("unused_read_count", rd1_cnt + rd2_cnt, snap1 + snap2);

        // Long stall on busy R5 saturates the counter, then reset mid-stall
        issue(mk(5'd6, 3'd5, 3'd0, 1, 0, 3'd0, 0, 16'hDEAD, 16'h0000), w);
        repeat (260) @(negedge clk);
        chk("stall_saturate", stall_cnt, 255);
        chk("stall_still_blocked", out_valid, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_stall_cnt", stall_cnt, 0);
        chk("midrst_out_op", out_op, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        issue(mk(5'd8, 3'd5, 3'd0, 1, 0, 3'd1, 0, 16'h0055, 16'h0000), w);
        chk("midrst_busy_cleared", rf_read1, 1);
        @(negedge clk);
        chk("midrst_dispatch", out_valid, 1);
        chk("midrst_no_stall", stall_cnt, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/opfetch.md
# opfetch

Operand-fetch stage of the CPU2 pipeline, sitting between the decoder and the execute unit and directly in front of the register file. It accepts one decoded instruction at a time, stalls on read-after-write hazards using a per-register busy scoreboard, and drives the register file's two combinational read ports. It forwards writeback data that arrives in the same cycle, then presents both operands to execute over a valid/ready handshake.

## Interface
- `DATA_W`, default 16: register width; equals `Rreg_Bus` width.
- `ADDR_W`, default 3: register address width (8 registers); equals `Rreg_AddrBus` width.
- `OP_W`, default 5: opcode width, passed through unchanged.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: decoder offers an instruction.
- `in_ready` out 1: the stage can accept an instruction this cycle.
- `in_op` in OP_W: opcode.
- `in_rs1`, `in_rs2` in ADDR_W: source register addresses.
- `in_use1`, `in_use2` in 1: the corresponding source operand is needed.
- `in_rd` in ADDR_W: destination register.
- `in_wen` in 1: the instruction writes `in_rd`.
- `rf_read1`, `rf_read2` out 1: register file read enables.
- `rf_addr1`, `rf_addr2` out ADDR_W: register file read addresses.
- `rf_data1`, `rf_data2` in DATA_W: register file read data; combinational, valid in the same cycle.
- `wb_valid` in 1: writeback commits `wb_data` to `wb_addr` this cycle.
- `wb_addr` in ADDR_W; `wb_data` in DATA_W: writeback address and data.
- `out_valid` out 1; `out_ready` in 1: handshake to execute.
- `out_op` out OP_W; `out_a`, `out_b` out DATA_W; `out_rd` out ADDR_W; `out_wen` out 1: the dispatched instruction and its operands.
- `stall_cnt` out 8: saturating count of hazard-stall cycles.

## Operation
- **FSM states:** IDLE, CHECK, OUT. Reset puts the FSM in IDLE.
- **Accept:** `in_ready` = (IDLE) or (OUT and `out_ready`). When `in_valid` and `in_ready` are both high, latch all `in_*` fields and go to CHECK.
- **CHECK, addresses:** `rf_addr1` and `rf_addr2` always drive the latched rs1 and rs2.
- **CHECK, hazard test:** source n is blocked if use_n is set, busy[rs_n] is set, and there is no `wb_valid` with `wb_addr` equal to rs_n in the same cycle.
- **CHECK, stall:** if any used source is blocked, stay in CHECK and increment `stall_cnt` (saturating at 255).
- **CHECK, proceed:** otherwise pulse `rf_read1` and/or `rf_read2` for each used source and capture the operands:
  - if `wb_valid` and `wb_addr` equals rs_n, take `wb_data`;
  - otherwise take `rf_data_n`;
  - an unused operand captures 0.
  Then go to OUT.
- **OUT:** hold `out_valid` high with all `out_*` stable until `out_ready`. On handoff:
  - if `out_wen`, set busy[out_rd];
  - go to CHECK if a new instruction was accepted in the same cycle, else go to IDLE.
- **Scoreboard:** a `wb_valid` pulse clears busy[wb_addr]. If a set and a clear hit the same address in the same cycle, the set wins. A clear of a register that is not busy has no effect. Register 0 is tracked like every other register.
- **Reset values (asserted at any time, including mid-stall):** state IDLE, busy all 0, `stall_cnt` 0, `out_valid` 0, all `out_*` 0, `rf_read*` 0, `in_ready` 1 once reset is released. Any in-flight instruction is dropped.

## Timing
- Accept at edge N puts the stage in CHECK during cycle N+1. With no hazard, `out_valid` rises in cycle N+2.
- Hazard stall: `out_valid` rises one cycle after the cycle in which the blocking writeback is seen.
- Throughput: one instruction every 2 cycles when `out_ready` is held high. Back-to-back dependent instructions add at least one stall cycle until writeback.
- `rf_read*` are high only in the single CHECK cycle that proceeds.
- `out_*` change only on the edge that leaves CHECK for OUT.

## Structure
- `DATA_W`, `ADDR_W` and `OP_W` defaults come from the `Rreg_Bus`, `Rreg_AddrBus` and opcode macros in the shared `def.v`. FSM state encodings are added to `def.v` as `OPF_IDLE`, `OPF_CHECK` and `OPF_OUT`.
- The scoreboard is split into one sub-module, `opf_scoreboard`: a 2^ADDR_W busy vector with set/clear ports (set wins) and two combinational busy lookups. Everything else stays in `opfetch`.

## Test plan
- **Basic:** after reset, issue op=3, rs1=1, rs2=2, rd=4, wen=1 with R1=0x0011 and R2=0x0022, `out_ready`=1. Expect `rf_read1`/`rf_read2` high for one cycle, then `out_a`=0x0011 and `out_b`=0x0022 two cycles after accept, and busy[4]=1.
- **RAW stall:** immediately issue rs1=4. Expect the stage to hold in CHECK with `stall_cnt` counting. Assert `wb_valid`, `wb_addr`=4, `wb_data`=0x1234; expect `out_a`=0x1234 (forwarded) on the next `out_valid`.
- **Backpressure:** `out_ready`=0 for 5 cycles. Expect `out_*` stable and `in_ready`=0 throughout; raise `out_ready` together with a new `in_valid` and expect the new instruction accepted in that same cycle.
- **Set/clear collision:** handoff with rd=2 and wen=1 in the same cycle as `wb_valid` with `wb_addr`=2. Expect busy[2]=1 afterward.
- **Unused operands:** issue with use1=0 and use2=0. Expect `rf_read*` never asserted and `out_a`=`out_b`=0, with no stall even if busy[rs] is set.
- **Reset mid-stall:** assert `rst_n`=0 while in CHECK. Expect `out_valid`=0, busy cleared and `stall_cnt`=0 immediately (asynchronous), and `in_ready`=1 after release.
